bus_memory_responder: RTL and testbench

// - Memory-side responder for the top8227 CPU bus: decodes AddressBusHigh/Low and readNotWrite.

---
 rtl/bus_memory_responder.sv | 183 ++++++++++++++++++
 tb/tb_bus_memory_responder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_memory_responder.sv
// bus_memory_responder: memory-side responder for the top8227 CPU bus.
// Holds RAM at 0x0000..RAM_DEPTH-1, a ROM window ROM_BASE..0xFFF9 and the
// six vector bytes 0xFFFA..0xFFFF. A host load port fills any mapped
// region while the CPU is held.
//
// State table:
//   IDLE | CPU owns the bus; reads return data, RAM writes are accepted
//   LOAD | host burst in progress; cpuHold=1, CPU bus ignored
//
// Optional feature macro: BUS_FAULT_EN adds a sticky busFault output that
// flags CPU writes to ROM/vector space and CPU accesses to unmapped space.
module bus_memory_responder #(
  parameter int          RAM_DEPTH    = 512,
  parameter logic [15:0] ROM_BASE     = 16'hF000,
  parameter logic [15:0] RESET_VECTOR = 16'hCCDD,
  parameter logic [15:0] NMI_VECTOR   = 16'h0000,
  parameter logic [15:0] IRQ_VECTOR   = 16'h0000,
  parameter int          READ_LATENCY = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  AddressBusHigh,
  input  logic [7:0]  AddressBusLow,
  input  logic        readNotWrite,
  input  logic [7:0]  dataBusOutput,
  output logic [7:0]  dataBusInput,
  input  logic        loadStart,
  input  logic [15:0] loadAddress,
  input  logic        loadValid,
  input  logic [7:0]  loadData,
  input  logic        loadDone,
  output logic        cpuHold,
  output logic [15:0] loadPointer
`ifdef BUS_FAULT_EN
  ,
  output logic        busFault
`endif
);

  localparam int          RAM_AW    = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam int          ROM_DEPTH = 65530 - int'(ROM_BASE);
  localparam int          ROM_AW    = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
  localparam logic [15:0] RAM_LIMIT = 16'(RAM_DEPTH);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t      state, state_next;
  logic [7:0]  ram [RAM_DEPTH];
  logic [7:0]  rom [ROM_DEPTH];
  logic [7:0]  vec [6];
  logic [7:0]  read_hold;
  logic [7:0]  rd_data;
  logic [15:0] cpu_addr;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        cpu_wr, load_wr;
  logic        ram_we, rom_we, vec_we;

  function automatic logic is_ram(input logic [15:0] a);
    return a < RAM_LIMIT;
  endfunction

  function automatic logic is_rom(input logic [15:0] a);
    return (a >= ROM_BASE) && (a <= 16'hFFF9);
  endfunction

  function automatic logic is_vec(input logic [15:0] a);
    return a >= 16'hFFFA;
  endfunction

  function automatic logic [RAM_AW-1:0] ram_idx(input logic [15:0] a);
    return a[RAM_AW-1:0];
  endfunction

  function automatic logic [ROM_AW-1:0] rom_idx(input logic [15:0] a);
    return ROM_AW'(a - ROM_BASE);
  endfunction

  // 0xFFFA..0xFFFF map onto vec[0..5]
  function automatic logic [2:0] vec_idx(input logic [15:0] a);
    return a[2:0] - 3'd2;
  endfunction

  assign cpu_addr = {AddressBusHigh, AddressBusLow};
  assign cpuHold  = (state == LOAD);

  // Read decode for the CPU address; unmapped space reads as 8'hFF
  always_comb begin
    rd_data = 8'hFF;
    if (is_ram(cpu_addr))      rd_data = ram[ram_idx(cpu_addr)];
    else if (is_rom(cpu_addr)) rd_data = rom[rom_idx(cpu_addr)];
    else if (is_vec(cpu_addr)) rd_data = vec[vec_idx(cpu_addr)];
  end

  // Single write port shared by CPU (RAM only) and host load (any mapped region)
  always_comb begin
    cpu_wr  = (state == IDLE) && !readNotWrite;
    load_wr = (state == LOAD) && loadValid;
    wr_addr = (state == LOAD) ? loadPointer : cpu_addr;
    wr_data = (state == LOAD) ? loadData : dataBusOutput;
    ram_we  = (cpu_wr || load_wr) && is_ram(wr_addr);
    rom_we  = load_wr && is_rom(wr_addr);
    vec_we  = load_wr && is_vec(wr_addr);
  end

  // RAM storage, not cleared by reset
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_idx(wr_addr)] <= wr_data;
  end

  // ROM storage, written only by the host load port
  always_ff @(posedge clk) begin
    if (rom_we) rom[rom_idx(wr_addr)] <= wr_data;
  end

  // Vector bytes reload their parameter values on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec[0] <= NMI_VECTOR[7:0];
      vec[1] <= NMI_VECTOR[15:8];
      vec[2] <= RESET_VECTOR[7:0];
      vec[3] <= RESET_VECTOR[15:8];
      vec[4] <= IRQ_VECTOR[7:0];
      vec[5] <= IRQ_VECTOR[15:8];
    end else if (vec_we) begin
      vec[vec_idx(wr_addr)] <= wr_data;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FSM next state; loadDone wins over a simultaneous restart
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (loadStart) state_next = LOAD;
      LOAD:    if (loadDone)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Load pointer: latched on loadStart, advances on every accepted byte, wraps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loadPointer <= 16'h0000;
    end else if (loadStart) begin
      loadPointer <= loadAddress;
    end else if (load_wr) begin
      loadPointer <= loadPointer + 16'd1;
    end
  end

  // Last CPU read byte; also the held output while the CPU is stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  read_hold <= 8'h00;
    else if ((state == IDLE) && readNotWrite) read_hold <= rd_data;
  end

  // Output select: combinational read path only at zero latency in IDLE
  always_comb begin
    dataBusInput = read_hold;
    if ((READ_LATENCY == 0) && (state == IDLE) && readNotWrite && !rst)
      dataBusInput = rd_data;
  end

`ifdef BUS_FAULT_EN
  // Sticky fault flag for illegal CPU accesses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busFault <= 1'b0;
    end else if ((state == IDLE) &&
                 (!(is_ram(cpu_addr) || is_rom(cpu_addr) || is_vec(cpu_addr)) ||
                  (!readNotWrite && !is_ram(cpu_addr)))) begin
      busFault <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bus_memory_responder.sv
// Testbench for bus_memory_responder: vector table, hand sequences for the
// load/wrap/reset corner cases, then random CPU traffic and load bursts
// checked against an address-map model.
`timescale 1ns/1ps
module tb_bus_memory_responder;

  localparam int RAM_DEPTH = 512;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  AddressBusHigh, AddressBusLow;
  logic        readNotWrite;
  logic [7:0]  dataBusOutput;
  logic [7:0]  dataBusInput;
  logic        loadStart;
  logic [15:0] loadAddress;
  logic        loadValid;
  logic [7:0]  loadData;
  logic        loadDone;
  logic        cpuHold;
  logic [15:0] loadPointer;
`ifdef BUS_FAULT_EN
  logic        busFault;
`endif

  bus_memory_responder dut (
    .clk(clk), .rst(rst),
    .AddressBusHigh(AddressBusHigh), .AddressBusLow(AddressBusLow),
    .readNotWrite(readNotWrite), .dataBusOutput(dataBusOutput),
    .dataBusInput(dataBusInput),
    .loadStart(loadStart), .loadAddress(loadAddress), .loadValid(loadValid),
    .loadData(loadData), .loadDone(loadDone),
    .cpuHold(cpuHold), .loadPointer(loadPointer)
`ifdef BUS_FAULT_EN
    , .busFault(busFault)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: flat 64K byte image plus "known" flags
  logic [7:0] m [65536];
  bit         k [65536];
  logic [7:0] last_rd;
  bit         last_k;
  bit         fault_m;

  typedef struct {
    logic [15:0] addr;
    logic        rnw;
    logic [7:0]  wd;
    logic [7:0]  exp;
    string       name;
  } vec_t;
  vec_t tbl [16];

  function automatic bit m_ram(input logic [15:0] a);
    return int'(a) < RAM_DEPTH;
  endfunction

  function automatic bit m_mapped(input logic [15:0] a);
    return m_ram(a) || (int'(a) >= 'hF000);
  endfunction

  function automatic void exp_rd(input logic [15:0] a, output logic [7:0] e, output bit kn);
    if (!m_mapped(a)) begin e = 8'hFF; kn = 1'b1; end
    else begin e = m[a]; kn = k[a]; end
  endfunction

  task automatic model_reset();
    m[16'hFFFA] = 8'h00; m[16'hFFFB] = 8'h00;
    m[16'hFFFC] = 8'hDD; m[16'hFFFD] = 8'hCC;
    m[16'hFFFE] = 8'h00; m[16'hFFFF] = 8'h00;
    for (int i = 16'hFFFA; i <= 16'hFFFF; i++) k[i] = 1'b1;
    last_rd = 8'h00; last_k = 1'b1; fault_m = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One CPU bus cycle; read data compared either to a given value or the model
  task automatic cpu(input logic [15:0] a, input logic rnw, input logic [7:0] wd,
                     input bit use_exp, input logic [7:0] expv, input string name);
    logic [7:0] e; bit kn;
    {AddressBusHigh, AddressBusLow} = a;
    readNotWrite = rnw;
    dataBusOutput = wd;
    #2;
`ifdef BUS_FAULT_EN
    chk("bus_fault", busFault, fault_m);
`endif
    chk({name, "_hold"}, cpuHold, 1'b0);
    if (rnw) begin
      exp_rd(a, e, kn);
      if (use_exp) chk(name, dataBusInput, expv);
      else if (kn) chk(name, dataBusInput, e);
      last_rd = e; last_k = kn;
    end else if (m_ram(a)) begin
      m[a] = wd; k[a] = 1'b1;
    end
    if (!m_mapped(a) || (!rnw && !m_ram(a))) fault_m = 1'b1;
    tick();
  endtask

  // Host load burst; CPU drives a stray write that must be ignored
  task automatic load_burst(input logic [15:0] start, input logic [7:0] q[$],
                            input bit done_with_last, input bit gaps);
    logic [15:0] ptr;
    logic [7:0]  e;
    bit          kn, v;
    int          i, guard;
    {AddressBusHigh, AddressBusLow} = 16'hFFFC;
    readNotWrite = 1'b1;
    exp_rd(16'hFFFC, e, kn);
    last_rd = e; last_k = kn;
    loadStart = 1'b1; loadAddress = start;
    tick();
    loadStart = 1'b0;
    {AddressBusHigh, AddressBusLow} = 16'h0001;
    readNotWrite = 1'b0; dataBusOutput = 8'hEE;
    ptr = start; i = 0; guard = 0;
    while (i < q.size()) begin
      v = gaps ? 1'($urandom % 2) : 1'b1;
      loadValid = v; loadData = q[i];
      loadDone = done_with_last && v && (i == q.size() - 1);
      #2;
      chk("load_hold", cpuHold, 1'b1);
      chk("load_ptr", loadPointer, ptr);
      if (last_k) chk("load_dbi_held", dataBusInput, last_rd);
      if (v) begin
        if (m_mapped(ptr)) begin m[ptr] = q[i]; k[ptr] = 1'b1; end
        ptr = ptr + 16'd1; i++;
      end
      tick();
      guard++;
      if (guard > 64) begin
        chk("load_budget", guard, 64);
        break;
      end
    end
    loadValid = 1'b0;
    if (!done_with_last) begin
      loadDone = 1'b1;
      #2 chk("done_cycle_hold", cpuHold, 1'b1);
      tick();
    end
    loadDone = 1'b0;
    {AddressBusHigh, AddressBusLow} = 16'hFFFC;
    readNotWrite = 1'b1;
    #2;
    chk("exit_hold", cpuHold, 1'b0);
    chk("exit_ptr", loadPointer, ptr);
  endtask

  function automatic logic [15:0] pick_addr();
    case ($urandom % 5)
      0: return 16'($urandom_range(0, 15));
      1: return 16'($urandom_range(RAM_DEPTH - 16, RAM_DEPTH - 1));
      2: return 16'($urandom_range('hF000, 'hF00F));
      3: return 16'($urandom_range('hFFF0, 'hFFFF));
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    logic [7:0] q[$];
    tbl[0]  = '{16'hFFFC, 1'b1, 8'h00, 8'hDD, "rst_vec_lo"};
    tbl[1]  = '{16'hFFFD, 1'b1, 8'h00, 8'hCC, "rst_vec_hi"};
    tbl[2]  = '{16'hFFFA, 1'b1, 8'h00, 8'h00, "nmi_lo"};
    tbl[3]  = '{16'hFFFB, 1'b1, 8'h00, 8'h00, "nmi_hi"};
    tbl[4]  = '{16'hFFFE, 1'b1, 8'h00, 8'h00, "irq_lo"};
    tbl[5]  = '{16'hFFFF, 1'b1, 8'h00, 8'h00, "irq_hi"};
    tbl[6]  = '{16'h01FF, 1'b0, 8'hA9, 8'h00, "wr_1ff"};
    tbl[7]  = '{16'h01FF, 1'b1, 8'h00, 8'hA9, "raw_1ff"};
    tbl[8]  = '{16'h0200, 1'b1, 8'h00, 8'hFF, "unmapped_200"};
    tbl[9]  = '{16'h0000, 1'b0, 8'h5A, 8'h00, "wr_000"};
    tbl[10] = '{16'h0000, 1'b1, 8'h00, 8'h5A, "raw_000"};
    tbl[11] = '{16'hFFFC, 1'b0, 8'h77, 8'h00, "wr_vec"};
    tbl[12] = '{16'hFFFC, 1'b1, 8'h00, 8'hDD, "vec_readonly"};
    tbl[13] = '{16'h8000, 1'b1, 8'h00, 8'hFF, "unmapped_8000"};
    tbl[14] = '{16'h0001, 1'b0, 8'h3C, 8'h00, "wr_001"};
    tbl[15] = '{16'h0001, 1'b1, 8'h00, 8'h3C, "raw_001"};

    for (int i = 0; i < 65536; i++) k[i] = 1'b0;
    model_reset();

    rst = 1'b1;
    {AddressBusHigh, AddressBusLow} = 16'hFFFC;
    readNotWrite = 1'b1; dataBusOutput = 8'h00;
    loadStart = 1'b0; loadAddress = 16'h0000;
    loadValid = 1'b0; loadData = 8'h00; loadDone = 1'b0;
    #3;
    chk("reset_hold", cpuHold, 1'b0);
    chk("reset_ptr", loadPointer, 16'h0000);
    chk("reset_dbi", dataBusInput, 8'h00);
`ifdef BUS_FAULT_EN
    chk("reset_fault", busFault, 1'b0);
`endif
    #9 rst = 1'b0;
    tick();

    foreach (tbl[i]) cpu(tbl[i].addr, tbl[i].rnw, tbl[i].wd, 1'b1, tbl[i].exp, tbl[i].name);

    // Burst into ROM, loadDone on its own cycle
    q = '{8'hA9, 8'h10, 8'h48};
    load_burst(16'hF000, q, 1'b0, 1'b0);
    chk("rom_ptr_end", loadPointer, 16'hF003);
    cpu(16'hF000, 1'b1, 8'h00, 1'b1, 8'hA9, "rom_f000");
    cpu(16'hF001, 1'b1, 8'h00, 1'b1, 8'h10, "rom_f001");
    cpu(16'hF002, 1'b1, 8'h00, 1'b1, 8'h48, "rom_f002");
    cpu(16'h0001, 1'b1, 8'h00, 1'b1, 8'h3C, "cpu_wr_ignored_in_load");

    // Burst through the IRQ vector and across the 0xFFFF wrap, done with last byte
    q = '{8'h11, 8'h22, 8'h33};
    load_burst(16'hFFFE, q, 1'b1, 1'b0);
    chk("wrap_ptr_end", loadPointer, 16'h0001);
    cpu(16'hFFFE, 1'b1, 8'h00, 1'b1, 8'h11, "irq_lo_loaded");
    cpu(16'hFFFF, 1'b1, 8'h00, 1'b1, 8'h22, "irq_hi_loaded");
    cpu(16'h0000, 1'b1, 8'h00, 1'b1, 8'h33, "wrap_ram0");
    cpu(16'hF000, 1'b0, 8'h55, 1'b0, 8'h00, "wr_rom");
    cpu(16'hF000, 1'b1, 8'h00, 1'b1, 8'hA9, "rom_readonly");

    // loadDone while idle does nothing
    loadDone = 1'b1;
    cpu(16'hFFFD, 1'b1, 8'h00, 1'b1, 8'hCC, "done_in_idle");
    loadDone = 1'b0;
    #2 chk("done_idle_ptr", loadPointer, 16'h0001);
    chk("done_idle_hold", cpuHold, 1'b0);
    tick();

    // Reset in the middle of a burst
    {AddressBusHigh, AddressBusLow} = 16'hFFFC; readNotWrite = 1'b1;
    loadStart = 1'b1; loadAddress = 16'h0100;
    tick();
    loadStart = 1'b0;
    {AddressBusHigh, AddressBusLow} = 16'h0001; readNotWrite = 1'b0; dataBusOutput = 8'hEE;
    loadValid = 1'b1; loadData = 8'h01;
    tick();
    loadData = 8'h02;
    tick();
    loadValid = 1'b0;
    m[16'h0100] = 8'h01; k[16'h0100] = 1'b1;
    m[16'h0101] = 8'h02; k[16'h0101] = 1'b1;
    #1 chk("mid_load_hold", cpuHold, 1'b1);
    chk("mid_load_ptr", loadPointer, 16'h0102);
    rst = 1'b1;
    #1 chk("rst_mid_hold", cpuHold, 1'b0);
    chk("rst_mid_ptr", loadPointer, 16'h0000);
    model_reset();
    #3 rst = 1'b0;
    readNotWrite = 1'b1;
    tick();
    cpu(16'hFFFC, 1'b1, 8'h00, 1'b1, 8'hDD, "rst_again_lo");
    cpu(16'hFFFD, 1'b1, 8'h00, 1'b1, 8'hCC, "rst_again_hi");
    cpu(16'hFFFE, 1'b1, 8'h00, 1'b1, 8'h00, "irq_reloaded");
    cpu(16'h0100, 1'b1, 8'h00, 1'b1, 8'h01, "kept_100");
    cpu(16'h0101, 1'b1, 8'h00, 1'b1, 8'h02, "kept_101");

    // Random traffic against the model
    for (int it = 0; it < 800; it++) begin
      if ($urandom % 100 < 6) begin
        q.delete();
        for (int j = 0; j < int'($urandom_range(1, 6)); j++) q.push_back(8'($urandom));
        load_burst(pick_addr(), q, 1'($urandom % 2), 1'b1);
        tick();
      end else begin
        cpu(pick_addr(), 1'($urandom % 2), 8'($urandom), 1'b0, 8'h00, "rand_rd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
